// File: rtl/demux_1_16.sv
// Registered 1-to-16 demultiplexer.
// The word on in1 is copied to the port chosen by sel (0 -> out1 ... 15 -> out16)
// on each rising clk edge; every other port is cleared on that same edge.
// Because every output comes from a flop, the block acts as a one-cycle
// routing stage, and no decode glitch can reach the consumers.

module demux_1_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [WIDTH-1:0] out8,
   output logic [WIDTH-1:0] out9,
   output logic [WIDTH-1:0] out10,
   output logic [WIDTH-1:0] out11,
   output logic [WIDTH-1:0] out12,
   output logic [WIDTH-1:0] out13,
   output logic [WIDTH-1:0] out14,
   output logic [WIDTH-1:0] out15,
   output logic [WIDTH-1:0] out16
);

   localparam int NUM_PORTS = 16;

   logic [WIDTH-1:0] port_d [NUM_PORTS];
   logic [WIDTH-1:0] port_q [NUM_PORTS];

   // Decode: selected port takes in1, all others zero.
   always_comb begin
      // NOTE: every port gets a default before the selective write, so no latch is inferred.
      for (int i = 0; i < NUM_PORTS; i++) begin
         port_d[i] = '0;
      end
      port_d[sel] = in1;
   end

   // Output registers with synchronous active-low clear; clear wins over any sel/in1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the port registers feed outputs directly, so all of them are cleared on reset.
         for (int i = 0; i < NUM_PORTS; i++) begin
            port_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking so every port updates from the same pre-edge values.
         for (int i = 0; i < NUM_PORTS; i++) begin
            port_q[i] <= port_d[i];
         end
      end
   end

   assign out1  = port_q[0];
   assign out2  = port_q[1];
   assign out3  = port_q[2];
   assign out4  = port_q[3];
   assign out5  = port_q[4];
   assign out6  = port_q[5];
   assign out7  = port_q[6];
   assign out8  = port_q[7];
   assign out9  = port_q[8];
   assign out10 = port_q[9];
   assign out11 = port_q[10];
   assign out12 = port_q[11];
   assign out13 = port_q[12];
   assign out14 = port_q[13];
   assign out15 = port_q[14];
   assign out16 = port_q[15];

endmodule

// File: tb/tb_demux_1_16.sv
// Self-checking bench for demux_1_16: directed scenarios, then random traffic,
// all compared against a simple "which port holds which word" reference model.

module tb_demux_1_16;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] in1;
   logic [3:0]       sel;
   logic [WIDTH-1:0] out1, out2, out3, out4, out5, out6, out7, out8;
   logic [WIDTH-1:0] out9, out10, out11, out12, out13, out14, out15, out16;

   logic [WIDTH-1:0] outs [16];
   logic [WIDTH-1:0] model [16];

   int checks = 0;
   int errors = 0;

   demux_1_16 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1),
      .sel   (sel),
      .out1  (out1),  .out2  (out2),  .out3  (out3),  .out4  (out4),
      .out5  (out5),  .out6  (out6),  .out7  (out7),  .out8  (out8),
      .out9  (out9),  .out10 (out10), .out11 (out11), .out12 (out12),
      .out13 (out13), .out14 (out14), .out15 (out15), .out16 (out16)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Gather outputs into an array for indexed comparison.
   assign outs[0]  = out1;  assign outs[1]  = out2;  assign outs[2]  = out3;  assign outs[3]  = out4;
   assign outs[4]  = out5;  assign outs[5]  = out6;  assign outs[6]  = out7;  assign outs[7]  = out8;
   assign outs[8]  = out9;  assign outs[9]  = out10; assign outs[10] = out11; assign outs[11] = out12;
   assign outs[12] = out13; assign outs[13] = out14; assign outs[14] = out15; assign outs[15] = out16;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string phase);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s out%0d", phase, i + 1), outs[i], model[i]);
      end
   endtask

   // One cycle: drive at negedge, optionally confirm outputs still hold before the
   // edge, then advance the model across the edge and compare after it.
   task automatic step(input logic r, input logic [3:0] s, input logic [WIDTH-1:0] d,
                       input bit hold_check, input string phase);
      @(negedge clk);
      rst_n = r;
      sel   = s;
      in1   = d;
      #1;
      if (hold_check) check_all({phase, " hold"});
      @(posedge clk);
      // Reference: after the edge, only the selected port carries the word, unless in reset.
      for (int i = 0; i < 16; i++) model[i] = '0;
      if (r) model[s] = d;
      #1;
      check_all(phase);
   endtask

   initial begin
      rst_n = 1'b0;
      sel   = 4'h7;
      in1   = 16'hFFFF;

      // 1. Reset dominates for two edges.
      step(1'b0, 4'h7, 16'hFFFF, 1'b0, "reset1");
      step(1'b0, 4'h7, 16'hFFFF, 1'b1, "reset2");

      // 2. Single route to out1.
      step(1'b1, 4'h0, 16'h3524, 1'b1, "single");

      // 3. Sweep all selector codes, including both boundaries.
      for (int s = 0; s < 16; s++) begin
         step(1'b1, 4'(s), 16'hA5A5, 1'b1, $sformatf("sweep%0d", s));
      end

      // 4. Data follow on out16.
      step(1'b1, 4'hF, 16'h0001, 1'b1, "follow1");
      step(1'b1, 4'hF, 16'hBEEF, 1'b1, "follow2");

      // 5. Reset mid-operation, then recovery.
      step(1'b1, 4'h5, 16'h1234, 1'b1, "mid_route");
      step(1'b0, 4'h5, 16'h1234, 1'b1, "mid_reset");
      step(1'b1, 4'h5, 16'h1234, 1'b1, "mid_recover");

      // 6. Selector change between edges: out4 holds until the edge, then out10 takes over.
      step(1'b1, 4'h3, 16'h00FF, 1'b1, "lat_a");
      step(1'b1, 4'h9, 16'h00FF, 1'b1, "lat_b");

      // Zero is a legal word.
      step(1'b1, 4'hA, 16'h0000, 1'b1, "zero_word");

      // Random traffic with occasional resets and zero words.
      for (int n = 0; n < 300; n++) begin
         logic             r;
         logic [3:0]       s;
         logic [WIDTH-1:0] d;
         r = ($urandom_range(15) != 0);
         s = 4'($urandom_range(15));
         d = ($urandom_range(9) == 0) ? '0 : WIDTH'($urandom);
         step(r, s, d, 1'b1, $sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
